// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder.
// It accepts one load or store, waits LATENCY cycles, and then performs the
// access against an internal little-endian word array. It holds the response
// until the initiator takes it. Faulting accesses return err=1 with zero data
// and never modify the array.

package dmem_pkg;
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;
endpackage

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    // Index width into the word array; the counter must hold LATENCY (min 1 bit).
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [DATA_WIDTH-1:0] DEPTH_LIM = DATA_WIDTH'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Control state (reset) and the registered response.
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    // Captured request (data path, no reset needed: only read after capture).
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Word array, four byte lanes per word, lane 0 = lowest address.
    logic [3:0][7:0]       mem_array [DEPTH_WORDS];

    logic [IDX_W-1:0]      word_idx;
    logic [1:0]            byte_off;
    logic [3:0][7:0]       rd_word;
    logic                  fault;
    logic                  mem_we;
    logic [3:0]            wr_be;
    logic [3:0][7:0]       wr_lanes;

    // Sign/zero extension of a selected byte or halfword to the bus width.
    function automatic logic [DATA_WIDTH-1:0] sext8(input logic signed [7:0] b);
        return {{(DATA_WIDTH-8){b[7]}}, b};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sext16(input logic signed [15:0] h);
        return {{(DATA_WIDTH-16){h[15]}}, h};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] zext8(input logic [7:0] b);
        return {{(DATA_WIDTH-8){1'b0}}, b};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] zext16(input logic [15:0] h);
        return {{(DATA_WIDTH-16){1'b0}}, h};
    endfunction

    // An access faults on an unknown opcode, a misaligned address, or an
    // address beyond the array.
    function automatic logic access_fault(input logic                  we,
                                          input logic [2:0]            f3,
                                          input logic [DATA_WIDTH-1:0] addr);
        logic misaligned;
        logic bad_op;
        logic out_of_range;
        misaligned = 1'b0;
        bad_op     = 1'b0;
        if (we) begin
            case (f3)
                FUNCT3_SB: misaligned = 1'b0;
                FUNCT3_SH: misaligned = addr[0];
                FUNCT3_SW: misaligned = |addr[1:0];
                default:   bad_op     = 1'b1;
            endcase
        end else begin
            case (f3)
                FUNCT3_LB, FUNCT3_LBU: misaligned = 1'b0;
                FUNCT3_LH, FUNCT3_LHU: misaligned = addr[0];
                FUNCT3_LW:             misaligned = |addr[1:0];
                default:               bad_op     = 1'b1;
            endcase
        end
        out_of_range = ({2'b00, addr[DATA_WIDTH-1:2]} >= DEPTH_LIM);
        return misaligned | bad_op | out_of_range;
    endfunction

    // Pick the addressed byte/half out of the word and extend it per opcode.
    function automatic logic [DATA_WIDTH-1:0] load_value(input logic [2:0]      f3,
                                                         input logic [1:0]      off,
                                                         input logic [3:0][7:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[off];
        h = off[1] ? {word[3], word[2]} : {word[1], word[0]};
        case (f3)
            FUNCT3_LB:  return sext8(b);
            FUNCT3_LH:  return sext16(h);
            FUNCT3_LW:  return word;
            FUNCT3_LBU: return zext8(b);
            FUNCT3_LHU: return zext16(h);
            default:    return '0;
        endcase
    endfunction

    // Byte-lane enables for a store at the given offset.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            FUNCT3_SB: return 4'b0001 << off;
            FUNCT3_SH: return off[1] ? 4'b1100 : 4'b0011;
            FUNCT3_SW: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Right-aligned store data replicated so every enabled lane sees its byte.
    function automatic logic [3:0][7:0] store_lanes(input logic [2:0]            f3,
                                                    input logic [DATA_WIDTH-1:0] wd);
        case (f3)
            FUNCT3_SB: return {4{wd[7:0]}};
            FUNCT3_SH: return {2{wd[15:0]}};
            default:   return wd[31:0];
        endcase
    endfunction

    assign word_idx = addr_q[IDX_W+1:2];
    assign byte_off = addr_q[1:0];
    assign fault    = access_fault(we_q, funct3_q, addr_q);
    assign wr_be    = store_be(funct3_q, byte_off);
    assign wr_lanes = store_lanes(funct3_q, wdata_q);

    // Read the addressed word combinationally for the access cycle.
    always_comb begin
        rd_word = mem_array[word_idx];
    end

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    cnt_d    = CNT_W'(LATENCY);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_we      = we_q & ~fault;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = fault;
                    rsp_rdata_d = (fault | we_q) ? '0
                                                 : load_value(funct3_q, byte_off, rd_word);
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM, wait counter and response registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Request capture registers.
    always_ff @(posedge clk) begin
        we_q     <= we_d;
        funct3_q <= funct3_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
    end

    // Byte-lane writes into the array; contents are not touched by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_array[word_idx][i] <= wr_lanes[i];
                end
            end
        end
    end

    assign req_ready_o = rst_n & (state_q == S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
